// File: rtl/lcd_write_arbiter.sv
// rtl/lcd_write_arbiter.sv - round-robin arbiter sharing a character LCD write bus
//
// Ports:
//   clk, rst       - system clock, synchronous active-high reset
//   init_done      - LCD init sequence complete; new grants only while high
//   req            - per-requester level request, held until ack
//   req_addr       - packed 7-bit DDRAM addresses, requester i at [7i+6:7i]
//   req_char       - packed 8-bit character codes, requester i at [8i+7:8i]
//   ack            - one-hot, one-cycle pulse when a request is captured
//   busy           - high from the cycle after ack until the return to IDLE
//   RS, RW, E, data - LCD bus (RW tied low, write only)
module lcd_write_arbiter #(
  parameter int N_REQ          = 3,
  parameter int SETUP_CYCLES   = 3,
  parameter int E_PULSE_CYCLES = 25,
  parameter int WAIT_CYCLES    = 2500
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               init_done,
  input  logic [N_REQ-1:0]   req,
  input  logic [N_REQ*7-1:0] req_addr,
  input  logic [N_REQ*8-1:0] req_char,
  output logic [N_REQ-1:0]   ack,
  output logic               busy,
  output logic               RS,
  output logic               RW,
  output logic               E,
  output logic [7:0]         data
);

  localparam int PW    = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int MAX_A = (SETUP_CYCLES > E_PULSE_CYCLES) ? SETUP_CYCLES : E_PULSE_CYCLES;
  localparam int MAX_C = (MAX_A > WAIT_CYCLES) ? MAX_A : WAIT_CYCLES;
  localparam int CW    = $clog2(MAX_C + 1);

  localparam logic [CW-1:0] S_LOAD = CW'(SETUP_CYCLES - 1);
  localparam logic [CW-1:0] P_LOAD = CW'(E_PULSE_CYCLES - 1);
  localparam logic [CW-1:0] W_LOAD = CW'(WAIT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE, A_SETUP, A_PULSE, A_WAIT, D_SETUP, D_PULSE, D_WAIT
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [PW-1:0] ptr;
  logic [6:0]    cur_addr;
  logic [7:0]    cur_char;
  logic [6:0]    shadow;
  logic          shadow_valid;

  logic          gnt_found;
  logic [PW-1:0] gnt_idx;

  assign RW = 1'b0;

  // DDRAM cursor after a write: line 1 ends at 0x27, line 2 ends at 0x67.
  function automatic logic [6:0] next_addr(input logic [6:0] a);
    if (a == 7'h27)      return 7'h40;
    else if (a == 7'h67) return 7'h00;
    else                 return a + 7'd1;
  endfunction

  function automatic logic addr_legal(input logic [6:0] a);
    return !((a >= 7'h28 && a <= 7'h3F) || a >= 7'h68);
  endfunction

  // Scan downward in offset so the smallest offset from ptr wins.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (req[(int'(ptr) + i) % N_REQ]) begin
        gnt_found = 1'b1;
        gnt_idx   = PW'((int'(ptr) + i) % N_REQ);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= '0;
      ptr          <= '0;
      cur_addr     <= '0;
      cur_char     <= '0;
      shadow       <= '0;
      shadow_valid <= 1'b0;
      ack          <= '0;
      busy         <= 1'b0;
      RS           <= 1'b0;
      E            <= 1'b0;
      data         <= 8'h00;
    end else begin
      ack <= '0;
      case (state)
        IDLE: begin
          if (ack != '0) begin
            // Ack cycle: launch the first phase; skip the address command
            // when the LCD cursor already points at the captured address.
            busy <= 1'b1;
            cnt  <= S_LOAD;
            if (shadow_valid && cur_addr == shadow) begin
              state <= D_SETUP;
              RS    <= 1'b1;
              data  <= cur_char;
            end else begin
              state <= A_SETUP;
              RS    <= 1'b0;
              data  <= {1'b1, cur_addr};
            end
          end else if (init_done && gnt_found) begin
            ack[gnt_idx] <= 1'b1;
            cur_addr     <= req_addr[7*gnt_idx +: 7];
            cur_char     <= req_char[8*gnt_idx +: 8];
            ptr          <= (gnt_idx == PW'(N_REQ - 1)) ? '0 : gnt_idx + 1'b1;
          end
        end

        A_SETUP, D_SETUP: begin
          if (cnt == '0) begin
            state <= (state == A_SETUP) ? A_PULSE : D_PULSE;
            cnt   <= P_LOAD;
            E     <= 1'b1;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end

        A_PULSE, D_PULSE: begin
          if (cnt == '0) begin
            state <= (state == A_PULSE) ? A_WAIT : D_WAIT;
            cnt   <= W_LOAD;
            E     <= 1'b0;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end

        A_WAIT: begin
          if (cnt == '0) begin
            state <= D_SETUP;
            cnt   <= S_LOAD;
            RS    <= 1'b1;
            data  <= cur_char;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end

        D_WAIT: begin
          if (cnt == '0) begin
            state        <= IDLE;
            busy         <= 1'b0;
            shadow       <= next_addr(cur_addr);
            shadow_valid <= addr_legal(cur_addr);
          end else begin
            cnt <= cnt - CW'(1);
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_write_arbiter.sv
// tb/tb_lcd_write_arbiter.sv - directed self-checking bench for lcd_write_arbiter
module tb_lcd_write_arbiter;

  localparam int S = 2;
  localparam int P = 3;
  localparam int W = 5;

  logic        clk = 1'b0;
  logic        rst;
  logic        init_done;
  logic [2:0]  req;
  logic [20:0] req_addr;
  logic [23:0] req_char;
  logic [2:0]  ack;
  logic        busy;
  logic        RS;
  logic        RW;
  logic        E;
  logic [7:0]  data;

  int checks   = 0;
  int failures = 0;

  lcd_write_arbiter #(
    .N_REQ(3), .SETUP_CYCLES(S), .E_PULSE_CYCLES(P), .WAIT_CYCLES(W)
  ) dut (
    .clk(clk), .rst(rst), .init_done(init_done), .req(req),
    .req_addr(req_addr), .req_char(req_char), .ack(ack), .busy(busy),
    .RS(RS), .RW(RW), .E(E), .data(data)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [6:0] a, input logic [7:0] c);
    req_addr[7*i +: 7] = a;
    req_char[8*i +: 8] = c;
  endtask

  task automatic wait_ack(output logic [2:0] got);
    got = '0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (ack != 3'b000) begin
        got = ack;
        break;
      end
    end
  endtask

  // Follows one transaction from the cycle after ack until busy drops,
  // recording each E pulse and counting bus-stability violations.
  task automatic observe(output int bcnt, output int np,
                         output logic [7:0] d0, output logic [7:0] d1,
                         output logic r0, output logic r1,
                         output int l0, output int l1,
                         output int viol, output int acks);
    logic       pe;
    logic [7:0] pd;
    logic       pr;
    int         since;
    bcnt = 0; np = 0; d0 = '0; d1 = '0; r0 = 1'b0; r1 = 1'b0;
    l0 = 0; l1 = 0; viol = 0; acks = 0;
    pe = E; pd = data; pr = RS; since = 0;
    for (int k = 0; k < 200; k++) begin
      tick();
      if (!busy) break;
      bcnt++;
      if (ack != 3'b000) acks++;
      if (data !== pd || RS !== pr) since = 0;
      else since++;
      if (E && !pe) begin
        np++;
        if (np == 1) begin d0 = data; r0 = RS; end
        else begin d1 = data; r1 = RS; end
        if (since < S) viol++;
      end
      if (E) begin
        if (np == 1) l0++;
        else l1++;
        if (data !== pd || RS !== pr) viol++;
      end
      pe = E; pd = data; pr = RS;
    end
  endtask

  // One write from requester i: exp_np is 2 for address+data, 1 for data only.
  task automatic txn(input string tag, input int i, input logic [6:0] a,
                     input logic [7:0] c, input int exp_np,
                     input logic [7:0] exp_cmd, input bit hold);
    logic [2:0] g;
    int bcnt, np, l0, l1, viol, acks;
    logic [7:0] d0, d1;
    logic r0, r1;
    set_req(i, a, c);
    req[i] = 1'b1;
    wait_ack(g);
    check({tag, "_ack"}, 32'(g), 32'(1) << i);
    if (!hold) req = 3'b000;
    observe(bcnt, np, d0, d1, r0, r1, l0, l1, viol, acks);
    check({tag, "_busy"}, bcnt, exp_np * (S + P + W));
    check({tag, "_pulses"}, np, exp_np);
    check({tag, "_stable"}, viol, 0);
    check({tag, "_reack"}, acks, 0);
    if (exp_np == 2) begin
      check({tag, "_cmd"}, {23'd0, r0, d0}, {24'd0, exp_cmd});
      check({tag, "_cmdlen"}, l0, P);
      check({tag, "_chr"}, {23'd0, r1, d1}, {23'd0, 1'b1, c});
      check({tag, "_chrlen"}, l1, P);
    end else begin
      check({tag, "_chr"}, {23'd0, r0, d0}, {23'd0, 1'b1, c});
      check({tag, "_chrlen"}, l0, P);
    end
  endtask

  initial begin
    int bad;
    logic [2:0] g;
    bit seen;

    rst = 1'b1; init_done = 1'b1; req = 3'b111; req_addr = '0; req_char = '0;

    // 1: reset held with requests pending, then init_done low after release
    bad = 0;
    for (int k = 0; k < 5; k++) begin
      tick();
      if (ack != 3'b000 || E || data != 8'h00 || busy || RS) bad++;
    end
    check("rst_hold", bad, 0);
    check("rw_tied", 32'(RW), 0);
    rst = 1'b0; init_done = 1'b0;
    bad = 0;
    for (int k = 0; k < 5; k++) begin
      tick();
      if (ack != 3'b000 || busy) bad++;
    end
    check("no_init_gate", bad, 0);
    req = 3'b000;

    // 2: first write is a miss: address command 0x85 then char 0x41
    init_done = 1'b1;
    txn("t2", 1, 7'h05, 8'h41, 2, 8'h85, 1'b0);

    // 3: auto-increment hit skips the address command
    txn("t3", 1, 7'h06, 8'h42, 1, 8'h00, 1'b0);

    // 4: all requesting with pointer at 2 -> 2,0,1,2
    set_req(0, 7'h10, 8'h30);
    set_req(1, 7'h11, 8'h31);
    set_req(2, 7'h12, 8'h32);
    req = 3'b111;
    txn("t4a", 2, 7'h12, 8'h32, 2, 8'h92, 1'b1);
    txn("t4b", 0, 7'h10, 8'h30, 2, 8'h90, 1'b1);
    txn("t4c", 1, 7'h11, 8'h31, 1, 8'h00, 1'b1);
    txn("t4d", 2, 7'h12, 8'h32, 1, 8'h00, 1'b0);

    // 5: line wraps and illegal addresses
    txn("t5a", 0, 7'h27, 8'h50, 2, 8'hA7, 1'b0);
    txn("t5b", 0, 7'h40, 8'h51, 1, 8'h00, 1'b0);
    txn("t5c", 0, 7'h67, 8'h52, 2, 8'hE7, 1'b0);
    txn("t5d", 0, 7'h41, 8'h53, 2, 8'hC1, 1'b0);
    txn("t5e", 0, 7'h30, 8'h54, 2, 8'hB0, 1'b0);
    txn("t5f", 0, 7'h31, 8'h55, 2, 8'hB1, 1'b0);

    // 6: reset during the data E pulse of a hit write
    txn("t6a", 0, 7'h05, 8'h61, 2, 8'h85, 1'b0);
    set_req(0, 7'h06, 8'h62);
    req = 3'b001;
    wait_ack(g);
    check("t6_ack", 32'(g), 32'h1);
    req = 3'b000;
    seen = 1'b0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (E) begin
        seen = 1'b1;
        break;
      end
    end
    check("t6_pulse_seen", 32'(seen), 1);
    check("t6_pulse_data", {23'd0, RS, data}, 32'h162);
    rst = 1'b1;
    tick();
    check("t6_rst_bus", {21'd0, ack, busy, RS, E, data}, 32'h0);
    rst = 1'b0;
    // pointer is back at 0, so 0 beats 2; shadow is invalid, so 0x06 misses
    set_req(2, 7'h20, 8'h70);
    req = 3'b100;
    txn("t6b", 0, 7'h06, 8'h63, 2, 8'h86, 1'b0);

    // init_done low blocks a fresh grant
    init_done = 1'b0;
    req = 3'b001;
    bad = 0;
    for (int k = 0; k < 5; k++) begin
      tick();
      if (ack != 3'b000) bad++;
    end
    check("t7_init_low", bad, 0);
    req = 3'b000;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
